dmem_bytelane: RTL

Parametrised single-port data memory for the core's MEM stage: replaces the fixed 32-entry word RAM with a configurable-depth array that supports byte, halfword and word stores through byte-lane masking. It also performs sign/zero-extended loads with a registered one-cycle read and clears the array in hardware after reset. It sits between the execute/memory pipeline register and the writeback mux. A req/ready/rvalid handshake stalls the pipeline during the post-reset clear sweep.

---
 rtl/dmem_bytelane_if.sv | 17 +
 rtl/dmem_bytelane.sv | 82 ++++++++
 2 files changed

// File: rtl/dmem_bytelane_if.sv
// dmem_bytelane_if: request/response bus between the MEM stage and the byte-lane data memory.
interface dmem_bytelane_if #(parameter int ADDR_W = 32);
  logic              i_req;
  logic              i_we;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_data;
  logic              o_ready;
  logic              o_rvalid;
  logic [31:0]       o_rdata;
  logic              o_err;
  modport master (output i_req, i_we, i_size, i_unsigned, i_addr, i_data,
                  input  o_ready, o_rvalid, o_rdata, o_err);
  modport slave  (input  i_req, i_we, i_size, i_unsigned, i_addr, i_data,
                  output o_ready, o_rvalid, o_rdata, o_err);
endinterface

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-lane masked data memory with registered extended loads and a post-reset clear sweep.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of force-aligning them.
module dmem_bytelane #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input logic             i_clk,
  input logic             i_rst_n,
  dmem_bytelane_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {INIT, IDLE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem [DEPTH];
  logic          acc, bad, wr, uns;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [AW-1:0] wi;
  logic [31:0]   wdata, sh, ext;
  logic          unused_ok;
  assign unused_ok = &{1'b0, bus.i_addr[ADDR_W-1:0]};
  assign wi  = bus.i_addr[AW+1:2];
  assign acc = bus.i_req && state_q == IDLE;
  assign uns = bus.i_unsigned;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign bad = bus.i_size == 2'b11 ||
               (bus.i_size == 2'b01 && bus.i_addr[0]) ||
               (bus.i_size == 2'b10 && bus.i_addr[1:0] != 2'b00);
`else
  assign bad = bus.i_size == 2'b11;
`endif
  // Lane offset also force-aligns: halfword drops addr[0], word drops addr[1:0]
  assign off   = bus.i_size == 2'b10 ? 2'b00 :
                 bus.i_size == 2'b01 ? {bus.i_addr[1], 1'b0} : bus.i_addr[1:0];
  assign be    = bus.i_size == 2'b10 ? 4'hf :
                 bus.i_size == 2'b01 ? 4'b0011 << off : 4'b0001 << off;
  assign wdata = bus.i_size == 2'b00 ? {4{bus.i_data[7:0]}} :
                 bus.i_size == 2'b01 ? {2{bus.i_data[15:0]}} : bus.i_data;
  assign wr    = acc && bus.i_we && !bad;
  assign sh    = mem[wi] >> {off, 3'b000};
  assign ext   = bus.i_size == 2'b00 ? {{24{~uns & sh[7]}}, sh[7:0]} :
                 bus.i_size == 2'b01 ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rvalid_d = acc && !bus.i_we && !bad;
    err_d    = acc && bad;
    rdata_d  = rvalid_d ? ext : rdata_q;
    if (state_q == INIT) begin
      idx_d   = idx_q + 1'b1;
      state_d = &idx_q ? IDLE : INIT;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= INIT;
      idx_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (state_q == INIT) mem[idx_q] <= '0;
    else if (wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[wi][8*b +: 8] <= wdata[8*b +: 8];
  end
  assign bus.o_ready  = state_q == IDLE;
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_rdata  = rdata_q;
  assign bus.o_err    = err_q;
endmodule
